driver_bus_master: RTL and testbench
====================================

// Module: driver_bus_master
// PURPOSE
//  Bus initiator for the driver register slave: turns queued host commands into
//  slave_wr/slave_rd cycles on the slave register port.
//  Supports single and burst writes (e.g. streaming vectors into the address FIFO
//  at 0x0) and single and burst reads (e.g. draining the addr_mon_cnts counters).
//  Returns read data on a valid/ready response stream.
//  Sits between the host command source and the slave register block.
// PARAMETERS
//  READ_LATENCY  1  cycles from a sampled slave_rd to valid slave_data_out (1..4)
//  ADDR_INC      4  address step per beat for incrementing bursts
// PORTS
//  clk            in   1   single clock, all logic on posedge
//  reset          in   1   synchronous, active-low reset
//  cmd_valid      in   1   command offered
//  cmd_ready      out  1   command accepted when valid&&ready; =1 only in IDLE
//  cmd_write      in   1   1=write burst, 0=read burst
//  cmd_fixed      in   1   1=hold address every beat, 0=increment by ADDR_INC
//  cmd_len        in   8   beats-1 (0 -> 1 beat, 255 -> 256 beats)
//  cmd_addr       in   32  first beat address
//  wdat_valid     in   1   write data offered
//  wdat_ready     out  1   =1 only in WRITE state
//  wdat_data      in   32  write beat data
//  rsp_valid      out  1   read data held
//  rsp_ready      in   1   response consumed when valid&&ready
//  rsp_data       out  32  read beat data
//  cmd_done       out  1   1-cycle pulse when a command completes
//  busy           out  1   =1 whenever state != IDLE
//  slave_addr     out  32  registered bus address
//  slave_wr       out  1   registered write strobe, 1 cycle per beat
//  slave_rd       out  1   registered read strobe, 1 cycle per beat
//  slave_data_in  out  32  registered write data
//  slave_data_out in   32  registered read data from the slave
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   - All outputs go to 0 on the next cycle, including slave_addr and rsp_data.
//   - State goes to IDLE; any in-flight command and held response are discarded.
//  States: IDLE, WRITE, READ, RD_WAIT, RSP.
//  IDLE:
//   - On cmd_valid, latch addr, len, fixed and beat_cnt=0.
//   - Go to WRITE if cmd_write=1, otherwise go to READ.
//  WRITE:
//   - On the edge where wdat_valid&&wdat_ready is seen, the next cycle drives
//     slave_wr=1, slave_addr=cur_addr, slave_data_in=wdat_data.
//   - If wdat_valid=0, drive slave_wr=0 and hold addr/data (gaps preserved).
//   - After the beat where beat_cnt==len: go to IDLE, cmd_done=1 in the cycle
//     after the last slave_wr.
//  READ:
//   - Drive slave_rd=1 and slave_addr=cur_addr for exactly one cycle (T).
//   - Then go to RD_WAIT.
//  RD_WAIT:
//   - Count READ_LATENCY cycles.
//   - Capture slave_data_out at the edge ending cycle T+READ_LATENCY.
//   - rsp_valid=1 from cycle T+READ_LATENCY+1; go to RSP.
//  RSP:
//   - Hold rsp_valid and rsp_data stable until rsp_ready.
//   - On accept: if beat_cnt==len go to IDLE with cmd_done=1, else go to READ.
//   - Only one read is in flight; no slave_rd is issued while a response is held.
//  Address and count rules:
//   - cur_addr += ADDR_INC after each beat unless fixed; wraps modulo 2^32.
//   - beat_cnt is 9 bits wide, so len=255 is 256 beats.
//   - slave_rd and slave_wr are never both 1.
//   - slave_addr holds its last value when neither strobe is active.
//  Throughput: writes 1 beat/cycle; reads 1 beat per READ_LATENCY+2 cycles when
//   rsp_ready=1.
// STRUCTURE
//  Shared package driver_pkg holds:
//   - the state enum;
//   - DRV_ADDR_FIFO_ADDR=32'h0 and DRV_CNTRL_ADDR=32'h1;
//   - the addr_mon_cnts base/stride constants.
//  No sub-module; the response holding register is inline.
// TESTING (bench includes a behavioural model of the slave register block)
//  1. Write cmd addr=0x0, len=0, wdat=0xDEAD_BEEF
//     -> exactly one slave_wr cycle, addr 0x0, data 0xDEADBEEF; cmd_done the
//     next cycle.
//  2. Fixed write len=3 at 0x0, wdat_valid low 1 cycle after beat 2
//     -> 4 slave_wr pulses, addr always 0x0, one idle cycle between beats 2 and
//     3, data in order.
//  3. Incrementing read len=1 at 0x0001_1004
//     -> slave_rd at 0x0001_1004 then 0x0001_1008; rsp_valid at T+2; rsp_data
//     equals the model counts[1] and counts[2].
//  4. Read with rsp_ready low for 5 cycles
//     -> rsp_valid held, rsp_data stable, no second slave_rd until accept.
//  5. Incrementing write at 0xFFFF_FFFC, len=1
//     -> second beat address is 0x0000_0000.
//  6. reset=0 during beat 2 of a len=7 write
//     -> next cycle all outputs 0 and busy=0; cmd_ready=1 in the first cycle
//     after reset=1.

Source files
------------

// File: rtl/driver_pkg.sv
// Shared types and address map for the driver register bus master.
// Holds the FSM encoding, command context and slave register constants.
package driver_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RD_WAIT,
    S_RSP
  } drv_state_t;

  typedef struct packed {
    logic [7:0] len;
    logic       fixed;
  } drv_cmd_t;

  localparam logic [31:0] DRV_ADDR_FIFO_ADDR = 32'h0000_0000;
  localparam logic [31:0] DRV_CNTRL_ADDR     = 32'h0000_0001;

  localparam logic [31:0] DRV_MON_CNT_BASE   = 32'h0001_1000;
  localparam logic [31:0] DRV_MON_CNT_STRIDE = 32'h0000_0004;
  localparam int          DRV_MON_CNT_NUM    = 16;

  function automatic logic [31:0] drv_step(
    input logic        fixed,
    input logic [31:0] inc
  );
    return fixed ? 32'h0 : inc;
  endfunction

  function automatic logic [31:0] drv_mon_addr(
    input int idx
  );
    return DRV_MON_CNT_BASE + DRV_MON_CNT_STRIDE * 32'(idx);
  endfunction

endpackage

// File: rtl/driver_bus_master.sv
// Bus initiator: turns host write/read bursts into registered
// slave_wr/slave_rd cycles and returns read beats on a response stream.
module driver_bus_master
  import driver_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_INC     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_fixed,
  input  logic [7:0]  cmd_len,
  input  logic [31:0] cmd_addr,
  input  logic        wdat_valid,
  output logic        wdat_ready,
  input  logic [31:0] wdat_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        cmd_done,
  output logic        busy,
  output logic [31:0] slave_addr,
  output logic        slave_wr,
  output logic        slave_rd,
  output logic [31:0] slave_data_in,
  input  logic [31:0] slave_data_out
);

  localparam logic [31:0] INC      = 32'(ADDR_INC);
  localparam logic [2:0]  LAT_LAST = 3'(READ_LATENCY - 1);

  drv_state_t  state;
  drv_state_t  state_n;
  drv_cmd_t    ctx;
  logic [31:0] cur_addr;
  logic [8:0]  beat_cnt;
  logic [2:0]  lat_cnt;
  logic        run;
  logic        done_pend;

  logic        accept;
  logic        wr_fire;
  logic        rsp_fire;
  logic        beat_last;
  logic        lat_done;
  logic        rd_issue;
  logic [31:0] issue_addr;
  logic [31:0] issue_step;

  // run stays low while reset is held so cmd_ready reads 0 then
  assign cmd_ready  = run && (state == S_IDLE);
  assign wdat_ready = (state == S_WRITE);
  assign busy       = (state != S_IDLE);

  assign accept    = cmd_valid && cmd_ready;
  assign wr_fire   = wdat_valid && wdat_ready;
  assign rsp_fire  = (state == S_RSP) && rsp_valid && rsp_ready;
  assign beat_last = (beat_cnt == {1'b0, ctx.len});
  assign lat_done  = (lat_cnt == LAT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state; a read strobe is launched on entry to READ
  always_comb begin
    state_n    = state;
    rd_issue   = 1'b0;
    issue_addr = cur_addr;
    issue_step = drv_step(ctx.fixed, INC);
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n    = cmd_write ? S_WRITE : S_READ;
          rd_issue   = !cmd_write;
          issue_addr = cmd_addr;
          issue_step = drv_step(cmd_fixed, INC);
        end
      end
      S_WRITE: begin
        if (wr_fire && beat_last) begin
          state_n = S_IDLE;
        end
      end
      S_READ: begin
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_done) begin
          state_n = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_fire) begin
          if (beat_last) begin
            state_n = S_IDLE;
          end else begin
            state_n  = S_READ;
            rd_issue = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Command context, beat/latency counters and done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctx       <= '0;
      cur_addr  <= '0;
      beat_cnt  <= '0;
      lat_cnt   <= '0;
      run       <= 1'b0;
      done_pend <= 1'b0;
      cmd_done  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        ctx.len   <= cmd_len;
        ctx.fixed <= cmd_fixed;
        beat_cnt  <= '0;
      end else if (wr_fire || rsp_fire) begin
        beat_cnt <= beat_cnt + 9'd1;
      end
      if (wr_fire || rd_issue) begin
        cur_addr <= issue_addr + issue_step;
      end else if (accept) begin
        cur_addr <= cmd_addr;
      end
      if (state == S_READ) begin
        lat_cnt <= '0;
      end else if (state == S_RD_WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
      done_pend <= wr_fire && beat_last;
      cmd_done  <= done_pend || (rsp_fire && beat_last);
    end
  end

  // Registered slave strobes; address/data hold between beats
  always_ff @(posedge clk) begin
    if (!reset) begin
      slave_wr      <= 1'b0;
      slave_rd      <= 1'b0;
      slave_addr    <= '0;
      slave_data_in <= '0;
    end else begin
      slave_wr <= wr_fire;
      slave_rd <= rd_issue;
      if (wr_fire) begin
        slave_addr    <= cur_addr;
        slave_data_in <= wdat_data;
      end else if (rd_issue) begin
        slave_addr <= issue_addr;
      end
    end
  end

  // Response holding register
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if ((state == S_RD_WAIT) && lat_done) begin
      rsp_valid <= 1'b1;
      rsp_data  <= slave_data_out;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_driver_bus_master.sv
// Self-checking bench for driver_bus_master with a behavioural
// register-slave model (address FIFO at 0x0, monitor counters).
module tb_driver_bus_master;
  import driver_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_fixed;
  logic [7:0]  cmd_len;
  logic [31:0] cmd_addr;
  logic        wdat_valid;
  logic        wdat_ready;
  logic [31:0] wdat_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        cmd_done;
  logic        busy;
  logic [31:0] slave_addr;
  logic        slave_wr;
  logic        slave_rd;
  logic [31:0] slave_data_in;
  logic [31:0] slave_data_out = 32'h0;

  always #5 clk = ~clk;

  driver_bus_master dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_fixed     (cmd_fixed),
    .cmd_len       (cmd_len),
    .cmd_addr      (cmd_addr),
    .wdat_valid    (wdat_valid),
    .wdat_ready    (wdat_ready),
    .wdat_data     (wdat_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .cmd_done      (cmd_done),
    .busy          (busy),
    .slave_addr    (slave_addr),
    .slave_wr      (slave_wr),
    .slave_rd      (slave_rd),
    .slave_data_in (slave_data_in),
    .slave_data_out(slave_data_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] prev_addr = 32'h0;

  logic [31:0] smem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] fifo_q[$];
  logic [31:0] counts[DRV_MON_CNT_NUM];

  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          wr_c[$];
  logic [31:0] rd_a[$];
  int          rd_c[$];
  int          done_c[$];

  // Slave register block: FIFO push at 0x0, 1-cycle registered reads
  always @(posedge clk) begin
    if (slave_wr) begin
      if (slave_addr == DRV_ADDR_FIFO_ADDR) fifo_q.push_back(slave_data_in);
      else smem[slave_addr] = slave_data_in;
    end
    if (slave_rd) begin
      slave_data_out <= smem.exists(slave_addr) ? smem[slave_addr] : 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {25'b0, cmd_ready, wdat_ready, rsp_valid, rsp_data, cmd_done,
            busy, slave_addr, slave_wr, slave_rd, slave_data_in};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic step();
    logic rs;
    rs = reset;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (slave_wr) begin
      wr_a.push_back(slave_addr);
      wr_d.push_back(slave_data_in);
      wr_c.push_back(cyc);
    end
    if (slave_rd) begin
      rd_a.push_back(slave_addr);
      rd_c.push_back(cyc);
    end
    if (cmd_done) done_c.push_back(cyc);
    chk("wr_rd_excl", slave_wr && slave_rd, 0);
    if (rs && !slave_wr && !slave_rd) chk("addr_hold", slave_addr, prev_addr);
    prev_addr = slave_addr;
  endtask

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    rd_a.delete(); rd_c.delete(); done_c.delete();
    fifo_q.delete();
  endtask

  task automatic do_cmd(input logic wr, input logic fx, input logic [7:0] len,
                        input logic [31:0] addr);
    int k;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_fixed = fx;
    cmd_len   = len;
    cmd_addr  = addr;
    k = 0;
    while (!cmd_ready && k < 20) begin
      step();
      k++;
    end
    chk("cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic fx, input logic [7:0] len,
                           input logic [31:0] addr, input int gap_idx,
                           input bit rnd_gap, input bit force_d0,
                           input logic [31:0] d0);
    logic [31:0] d[256];
    int gaps[256];
    logic [31:0] ea;
    logic [31:0] exp_fifo[$];
    int n;
    int k;
    n = int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      d[i] = (force_d0 && i == 0) ? d0 : $urandom;
      gaps[i] = (i == gap_idx) ? 1 :
                (rnd_gap && i > 0) ? int'($urandom_range(0, 1)) : 0;
    end
    clear_logs();
    do_cmd(1'b1, fx, len, addr);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        wdat_valid = 1'b0;
        step();
      end
      wdat_valid = 1'b1;
      wdat_data  = d[i];
      k = 0;
      while (!wdat_ready && k < 20) begin
        step();
        k++;
      end
      chk("wdat_ready", wdat_ready, 1);
      step();
    end
    wdat_valid = 1'b0;
    step();
    step();
    chk("wr_count", wr_a.size(), n);
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      ea = addr + (fx ? 32'h0 : 32'(4 * i));
      chk("wr_addr", wr_a[i], ea);
      chk("wr_data", wr_d[i], d[i]);
      if (i > 0) chk("wr_spacing", wr_c[i] - wr_c[i-1], 1 + gaps[i]);
      if (ea == DRV_ADDR_FIFO_ADDR) exp_fifo.push_back(d[i]);
      else ref_mem[ea] = d[i];
    end
    chk("wr_done_cnt", done_c.size(), 1);
    if (done_c.size() > 0 && wr_c.size() > 0)
      chk("wr_done_cyc", done_c[0], wr_c[wr_c.size()-1] + 1);
    chk("fifo_cnt", fifo_q.size(), exp_fifo.size());
    for (int i = 0; i < exp_fifo.size() && i < fifo_q.size(); i++)
      chk("fifo_data", fifo_q[i], exp_fifo[i]);
    chk("wr_idle", {busy, cmd_ready}, 2'b01);
  endtask

  task automatic run_read(input logic fx, input logic [7:0] len,
                          input logic [31:0] addr, input int stall_idx,
                          input int stall_n, input bit rnd_stall);
    logic [31:0] ea;
    logic [31:0] held;
    int last_acc;
    int s;
    int k;
    clear_logs();
    last_acc = 0;
    do_cmd(1'b0, fx, len, addr);
    for (int i = 0; i <= int'(len); i++) begin
      ea = addr + (fx ? 32'h0 : 32'(4 * i));
      k = 0;
      while (!rsp_valid && k < 20) begin
        step();
        k++;
      end
      chk("rsp_timeout", rsp_valid, 1);
      chk("rd_issued", rd_c.size(), i + 1);
      if (rd_c.size() > 0) begin
        chk("rsp_latency", cyc - rd_c[rd_c.size()-1], 2);
        chk("rd_addr", rd_a[rd_a.size()-1], ea);
        if (i > 0) chk("rd_after_acc", rd_c[rd_c.size()-1], last_acc + 1);
      end
      s = (i == stall_idx) ? stall_n :
          rnd_stall ? int'($urandom_range(0, 3)) : 0;
      held = rsp_data;
      for (int j = 0; j < s; j++) begin
        step();
        chk("rsp_held", rsp_valid, 1);
        chk("rsp_stable", rsp_data, held);
        chk("rd_blocked", rd_c.size(), i + 1);
      end
      chk("rsp_data", rsp_data, ref_rd(ea));
      last_acc = cyc;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    chk("rd_done_cnt", done_c.size(), 1);
    if (done_c.size() > 0) chk("rd_done_cyc", done_c[0], last_acc + 1);
    chk("rd_end", {rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    logic [31:0] base;
    logic [7:0]  len;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_fixed  = 1'b0;
    cmd_len    = 8'h0;
    cmd_addr   = 32'h0;
    wdat_valid = 1'b0;
    wdat_data  = 32'h0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < DRV_MON_CNT_NUM; i++) begin
      counts[i] = $urandom;
      smem[drv_mon_addr(i)] = counts[i];
      ref_mem[drv_mon_addr(i)] = counts[i];
    end

    step();
    step();
    chk("reset_outputs", outs(), 0);
    reset = 1'b1;
    step();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    run_write(1'b0, 8'd0, 32'h0, -1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    run_write(1'b1, 8'd3, 32'h0, 2, 1'b0, 1'b0, 32'h0);
    run_read(1'b0, 8'd1, 32'h0001_1004, -1, 0, 1'b0);
    chk("counts_probe", ref_rd(32'h0001_1008), counts[2]);
    run_read(1'b0, 8'd1, drv_mon_addr(5), 0, 5, 1'b0);
    run_write(1'b0, 8'd1, 32'hFFFF_FFFC, -1, 1'b0, 1'b0, 32'h0);

    for (int n = 0; n < 8; n++) begin
      base = 32'h2000_0000 + 32'(4 * $urandom_range(0, 63));
      len  = 8'($urandom_range(0, 7));
      run_write(1'($urandom_range(0, 1)), len, base, -1, 1'b1, 1'b0, 32'h0);
      run_read(1'($urandom_range(0, 1)), len, base, -1, 0, 1'b1);
      run_read(1'b0, 8'($urandom_range(0, 7)),
               drv_mon_addr(int'($urandom_range(0, 8))), -1, 0, 1'b1);
    end

    run_write(1'b0, 8'd255, 32'h4000_0000, -1, 1'b0, 1'b0, 32'h0);

    clear_logs();
    do_cmd(1'b1, 1'b0, 8'd7, 32'h3000_0040);
    wdat_valid = 1'b1;
    wdat_data  = $urandom;
    step();
    wdat_data  = $urandom;
    step();
    chk("t6_beat2", {slave_wr, slave_addr}, {1'b1, 32'h3000_0044});
    reset      = 1'b0;
    wdat_valid = 1'b0;
    step();
    chk("t6_rst_outputs", outs(), 0);
    reset = 1'b1;
    step();
    chk("t6_ready", {cmd_ready, busy, slave_wr}, 3'b100);
    run_write(1'b0, 8'd2, 32'h3000_0100, -1, 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
